pitch_gen: RTL and testbench
============================

Name: pitch_gen

Overview:
Square-wave tone generator for the music box. Converts a 6-bit note index into an audio-rate square wave, `pitch_clk`, by dividing the 100 MHz system clock. The note index comes from the sequencer/keyboard logic. `pitch_clk` drives the speaker/PWM stage. An octave-up control `hl` shifts any note up one octave.

Parameters:
- CNT_W, 20, width of the half-period counter. It must hold 764,456; the minimum value is 20.
- CLK_HZ, 100000000, system clock frequency. Documentation only: the table below is fixed for 100 MHz.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset_  input  1  asynchronous, active-low reset.
- scale  input  6  note index. 0..59 = C2..B6 chromatic; 60..63 = rest.
- hl  input  1  1 = play one octave higher; 0 = nominal octave.
- pitch_clk  output  1  square-wave tone output, 50% duty.

Behaviour:
- One clock domain, `clk`. Reset is asynchronous and active-low on `reset_`. All state is reset while `reset_` = 0.
- Reset values:
  - `pitch_clk` = 0
  - counter = 0
  - registered scale = 0
  - registered hl = 0
- Note decode:
  - note = `scale` mod 12
  - octave = `scale` / 12, range 0..4
  - shift = octave + `hl`, range 0..5
- Base half-period table in clk cycles, octave 2 (C2..B2), `note` 0..11:
  764456, 721542, 681051, 642822, 606745, 572692, 540546, 510209, 481575, 454545, 429033, 404951.
- half = table[note] >> shift, a logical right shift with truncation.
- Counter operation:
  - The counter increments each clk.
  - When counter == half-1: counter goes to 0 and `pitch_clk` toggles.
  - Output period = 2*half clk cycles.
- Input change handling:
  - `scale` and `hl` are registered every cycle.
  - When either registered value differs from the current input, the counter clears to 0 on the next edge. `pitch_clk` keeps its level.
  - The new half-period is therefore timed from that clear. This gives 1 cycle of input latency.
- Rest (`scale` >= 60):
  - The counter is held at 0 and `pitch_clk` is forced to 0 on the next edge.
  - Leaving rest starts from counter 0 with `pitch_clk` = 0.
- Reset mid-tone: `pitch_clk` goes to 0 immediately (asynchronous). It restarts from counter 0 after `reset_` rises.
- Counter compare is never against 0: the minimum half is 12654. No zero-length or overflow case exists.

Optional Feature:
- Macro PITCH_ACTIVE_EN.
- When defined: adds output port `active` (1 bit).
  - `active` = 1 while the registered scale is < 60 and not in reset; 0 during rest or reset.
  - `active` is a registered output with reset value 0.
  - It updates on the same edge the rest condition is applied or removed.
- When undefined: the port and its logic are absent. `pitch_clk` behaviour is identical in both builds.

Test Plan:
- `reset_`=0, any `scale`/`hl` -> `pitch_clk`=0 and constant; assert `reset_` low mid-tone -> `pitch_clk` falls asynchronously.
- `reset_`=1, `scale`=33 (A4), `hl`=0 -> `pitch_clk` toggles every 113,636 clk; period 2,272,720 ns = 440 Hz.
- `scale`=59, `hl`=1 -> toggles every 12,654 clk (126.54 us); then `hl`=0 -> counter clears, then toggles every 25,309 clk.
- `scale`=0, `hl`=0 -> half = 764,456 clk; check that the counter does not overflow.
- `scale`=62 during a tone -> `pitch_clk`=0 within 1 clk and stays low; `active`=0 if PITCH_ACTIVE_EN. Return to `scale`=9 -> first toggle after 454545>>0 = 454,545 clk.
- Change `scale` 33->34 mid half-period -> counter restarts; the next toggle occurs exactly 107,258 clk after the clear cycle (429033>>2).

Source files
------------

// File: rtl/pitch_gen_if.sv
// Note/tone bus between the sequencer (master) and pitch_gen (slave).
// The active flag exists only when PITCH_ACTIVE_EN is defined.
interface pitch_gen_if;
  logic [5:0] scale;
  logic       hl;
  logic       pitch_clk;
`ifdef PITCH_ACTIVE_EN
  logic       active;
  modport master (output scale, hl, input  pitch_clk, active);
  modport slave  (input  scale, hl, output pitch_clk, active);
`else
  modport master (output scale, hl, input  pitch_clk);
  modport slave  (input  scale, hl, output pitch_clk);
`endif
endinterface

// File: rtl/pitch_gen.sv
// Square-wave tone generator: note index -> half-period divider of the 100 MHz clock.
// Optional PITCH_ACTIVE_EN adds a registered 'active' flag (low during rest/reset).
module pitch_gen #(
  parameter int CNT_W  = 20,
  parameter int CLK_HZ = 100_000_000
) (
  input  logic      clk,
  input  logic      reset_,
  pitch_gen_if.slave sif
);

  if (CNT_W < 20 || CLK_HZ != 100_000_000) begin : g_cfg_err
    $error("pitch_gen: half-period table needs CNT_W >= 20 and a 100 MHz clock");
  end

  // Octave-2 half periods in clk cycles; higher octaves are right shifts of these.
  function automatic logic [19:0] base_half(input logic [3:0] n);
    case (n)
      4'd0:    base_half = 20'd764456;
      4'd1:    base_half = 20'd721542;
      4'd2:    base_half = 20'd681051;
      4'd3:    base_half = 20'd642822;
      4'd4:    base_half = 20'd606745;
      4'd5:    base_half = 20'd572692;
      4'd6:    base_half = 20'd540546;
      4'd7:    base_half = 20'd510209;
      4'd8:    base_half = 20'd481575;
      4'd9:    base_half = 20'd454545;
      4'd10:   base_half = 20'd429033;
      default: base_half = 20'd404951;
    endcase
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d, half;
  logic [5:0]       scale_q, scale_d;
  logic             hl_q, hl_d;
  logic             pitch_q, pitch_d;
  logic [3:0]       note;
  logic [2:0]       octave, shift;
  logic             rest, chg;

  // Half period follows the registered note, so it is stable one cycle after a change.
  always_comb begin
    note   = 4'(scale_q % 6'd12);
    octave = 3'(scale_q / 6'd12);
    shift  = octave + {2'b00, hl_q};
    half   = CNT_W'(base_half(note)) >> shift;
  end

  always_comb begin
    scale_d = sif.scale;
    hl_d    = sif.hl;
    rest    = (sif.scale >= 6'd60);
    chg     = (sif.scale != scale_q) || (sif.hl != hl_q);
    cnt_d   = cnt_q + CNT_W'(1);
    pitch_d = pitch_q;
    if (rest) begin
      cnt_d   = '0;
      pitch_d = 1'b0;
    end else if (chg) begin
      // restart timing of the new note from here, keeping the current output level
      cnt_d = '0;
    end else if (cnt_q == half - CNT_W'(1)) begin
      cnt_d   = '0;
      pitch_d = ~pitch_q;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt_q   <= '0;
      scale_q <= '0;
      hl_q    <= 1'b0;
      pitch_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      scale_q <= scale_d;
      hl_q    <= hl_d;
      pitch_q <= pitch_d;
    end
  end

  assign sif.pitch_clk = pitch_q;

`ifdef PITCH_ACTIVE_EN
  logic active_q, active_d;

  always_comb active_d = ~rest;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) active_q <= 1'b0;
    else         active_q <= active_d;
  end

  assign sif.active = active_q;
`endif

endmodule

// File: tb/tb_pitch_gen.sv
// Bench for pitch_gen: directed tone timing plus randomized note/rest/reset traffic
// checked against an elapsed-time reference model of the tone output.
module tb_pitch_gen;

  logic clk = 1'b0;
  logic reset_;
  int unsigned n_chk = 0, n_fail = 0;
  logic mon_en = 1'b0;

  pitch_gen_if u_if ();

  pitch_gen #(.CNT_W(20), .CLK_HZ(100_000_000)) u_dut (
    .clk   (clk),
    .reset_(reset_),
    .sif   (u_if.slave)
  );

  always #5 clk = ~clk;

  localparam int unsigned TBL [12] = '{764456, 721542, 681051, 642822, 606745, 572692,
                                       540546, 510209, 481575, 454545, 429033, 404951};

  function automatic int unsigned ref_half(input int s, input int h);
    return TBL[s % 12] >> (s / 12 + h);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the output is a function of edges elapsed since the last restart point.
  int unsigned m_n = 0, m_anchor = 0, m_half = 764456;
  logic        m_base = 1'b0, m_exp = 1'b0, m_act = 1'b0;
  logic [5:0]  m_ps = '0;
  logic        m_ph = 1'b0;

  always @(posedge clk) begin
    int unsigned nn, an, hf;
    logic bs, ep;
    nn = m_n + 1; an = m_anchor; hf = m_half; bs = m_base; ep = m_exp;
    if (!reset_) begin
      an = nn; bs = 1'b0; ep = 1'b0; hf = ref_half(0, 0);
      m_ps <= '0; m_ph <= 1'b0;
    end else if (u_if.scale >= 60) begin
      an = nn; bs = 1'b0; ep = 1'b0;
      m_ps <= u_if.scale; m_ph <= u_if.hl;
    end else begin
      if (u_if.scale != m_ps || u_if.hl != m_ph) begin
        an = nn; bs = ep; hf = ref_half(int'(u_if.scale), int'(u_if.hl));
      end
      ep = bs ^ (((nn - an) / hf) % 2 != 0);
      m_ps <= u_if.scale; m_ph <= u_if.hl;
    end
    m_n <= nn; m_anchor <= an; m_half <= hf; m_base <= bs; m_exp <= ep;
    m_act <= reset_ && (u_if.scale < 60);
  end

  // Compare whenever the DUT or the model output moves; between moves both are constant.
  logic last_p = 1'b0, last_e = 1'b0, last_a = 1'b0, last_ea = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (u_if.pitch_clk !== last_p || m_exp !== last_e) chk("pitch_trace", u_if.pitch_clk, m_exp);
`ifdef PITCH_ACTIVE_EN
      if (u_if.active !== last_a || m_act !== last_ea) chk("active_trace", u_if.active, m_act);
      last_a <= u_if.active; last_ea <= m_act;
`endif
    end
    last_p <= u_if.pitch_clk; last_e <= m_exp;
  end

  // Counts negedges until pitch_clk moves; caller starts just after the restart edge.
  task automatic measure(input string tag, input int unsigned exp_c);
    int unsigned c;
    logic l;
    c = 0; l = u_if.pitch_clk;
    do begin
      @(negedge clk);
      c++;
    end while (u_if.pitch_clk == l && c < exp_c + 100);
    chk(tag, c, exp_c);
  endtask

  initial begin
    reset_ = 1'b0; u_if.scale = '0; u_if.hl = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      u_if.scale = 6'($urandom_range(0, 63));
      u_if.hl    = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_pitch", u_if.pitch_clk, 0);
`ifdef PITCH_ACTIVE_EN
      chk("rst_active", u_if.active, 0);
`endif
    end

    // B6 one octave up: shortest half period
    u_if.scale = 6'd59; u_if.hl = 1'b1; reset_ = 1'b1;
    @(negedge clk);
    measure("b6_hl_first", 12654);
    measure("b6_hl_period", 12654);
    u_if.hl = 1'b0;
    @(negedge clk);
    measure("b6_hl0_after_clear", 25309);
    chk("level_before_reset", u_if.pitch_clk, 1);

    #1 reset_ = 1'b0;
    #1 chk("async_reset_drop", u_if.pitch_clk, 0);
    repeat (3) @(negedge clk);

    // change note mid half-period: timing restarts at the clear edge
    u_if.scale = 6'd57; u_if.hl = 1'b1; reset_ = 1'b1;
    repeat (5000) @(negedge clk);
    u_if.scale = 6'd58;
    @(negedge clk);
    measure("mid_change_58", 13407);

    u_if.scale = 6'd62;
    @(negedge clk);
    chk("rest_pitch_low", u_if.pitch_clk, 0);
`ifdef PITCH_ACTIVE_EN
    chk("rest_active_low", u_if.active, 0);
`endif
    repeat (50) @(negedge clk);
    chk("rest_pitch_hold", u_if.pitch_clk, 0);

    u_if.scale = 6'd9; u_if.hl = 1'b0;
    @(negedge clk);
    chk("leave_rest_pitch", u_if.pitch_clk, 0);
`ifdef PITCH_ACTIVE_EN
    chk("leave_rest_active", u_if.active, 1);
`endif
    repeat (1500) @(negedge clk);
    u_if.scale = 6'd0;
    repeat (1500) @(negedge clk);
    chk("c2_no_toggle_yet", u_if.pitch_clk, 0);

    for (int i = 0; i < 12; i++) begin
      int unsigned r;
      r = $urandom_range(0, 7);
      if (r == 0) begin
        reset_ = 1'b0;
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
      end
      if (r < 2) u_if.scale = 6'($urandom_range(60, 63));
      else       u_if.scale = 6'($urandom_range(48, 59));
      u_if.hl = 1'($urandom_range(0, 1));
      repeat ($urandom_range(200, 1500)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
